// File: rtl/dmem_pkg.sv
// Shared constants and store-buffer entry type for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_MEM_WORDS_DEF = 256;
  localparam int unsigned DMEM_WB_DEPTH_DEF  = 4;
  localparam int unsigned DMEM_IDX_W         = 30;

  typedef struct packed {
    logic [DMEM_IDX_W-1:0] index;
    logic [31:0]           data;
  } store_entry_t;

endpackage

// File: rtl/dmem_store_buf.sv
// FIFO store buffer with parallel index match; the youngest matching entry wins.
module dmem_store_buf
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_WB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DMEM_IDX_W-1:0] push_index_i,
  input  logic [31:0]           push_data_i,
  input  logic                  pop_i,
  input  logic [DMEM_IDX_W-1:0] lookup_index_i,
  output logic                  hit_o,
  output logic [31:0]           hit_data_o,
  output logic [DMEM_IDX_W-1:0] head_index_o,
  output logic [31:0]           head_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  store_entry_t   entries_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  pos;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !reset) entries_q[tail_q] <= '{index: push_index_i, data: push_data_i};
  end

  // Walk from oldest to youngest so a later (younger) match overrides.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    pos        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pos = head_q + PW'(i);
      if (i < 32'(count_q) && entries_q[pos].index == lookup_index_i) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[pos].data;
      end
    end
  end

  assign head_index_o = entries_q[head_q].index;
  assign head_data_o  = entries_q[head_q].data;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a posted store buffer; loads own the array port.
// Optional macro DMEM_FWD_EN: forward load data from pending stores instead of stalling.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DMEM_MEM_WORDS_DEF,
  parameter int unsigned WB_DEPTH  = DMEM_WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluout,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] readdata,
  output logic        mem_stall,
  output logic        wb_empty
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [AW-1:0]         idx;
  logic [DMEM_IDX_W-1:0] idx_ext;
  logic                  hit, empty, full;
  logic [31:0]           hit_data;
  logic [DMEM_IDX_W-1:0] head_index;
  logic [31:0]           head_data;
  logic                  is_load, load_stall, load_acc, drain, store_stall, push;
  logic [31:0]           mem_q [MEM_WORDS];
  logic                  unused_bits;

  assign idx     = aluout[AW+1:2];
  assign idx_ext = DMEM_IDX_W'(idx);

  dmem_store_buf #(.DEPTH(WB_DEPTH)) u_store_buf (
    .clk            (clk),
    .reset          (reset),
    .push_i         (push),
    .push_index_i   (idx_ext),
    .push_data_i    (write_data),
    .pop_i          (drain),
    .lookup_index_i (idx_ext),
    .hit_o          (hit),
    .hit_data_o     (hit_data),
    .head_index_o   (head_index),
    .head_data_o    (head_data),
    .empty_o        (empty),
    .full_o         (full)
  );

  // A write+read cycle is a store only; a full buffer still accepts a store
  // when the head drains in the same cycle.
  always_comb begin
    is_load     = mem_read & ~mem_write;
`ifdef DMEM_FWD_EN
    load_stall  = 1'b0;
`else
    load_stall  = is_load & hit;
`endif
    load_acc    = ~reset & is_load & ~load_stall;
    drain       = ~reset & ~empty & ~load_acc;
    store_stall = ~reset & mem_write & full & ~drain;
    push        = ~reset & mem_write & ~store_stall;
    mem_stall   = store_stall | (~reset & load_stall);
    wb_empty    = reset | empty;
    readdata    = '0;
    if (load_acc) begin
`ifdef DMEM_FWD_EN
      readdata = hit ? hit_data : mem_q[idx];
`else
      readdata = mem_q[idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (drain) mem_q[head_index[AW-1:0]] <= head_data;
  end

`ifdef DMEM_FWD_EN
  assign unused_bits = ^{aluout[31:AW+2], aluout[1:0], head_index[DMEM_IDX_W-1:AW]};
`else
  assign unused_bits = ^{aluout[31:AW+2], aluout[1:0], head_index[DMEM_IDX_W-1:AW], hit_data};
`endif

endmodule
